phase_error_detector: RTL and testbench

- Produces one signed error sample per reference period from the phase difference between reference and DCO feedback edges.
- Timing is measured by counting cycles of the fast system clock.
- One instance per loop channel; each instance drives one signed error input of the ADPLL error combiner, i.e. it is the producer side of that error interface.
- Emits a single-cycle valid strobe with each new sample.

---
 rtl/adpll_pkg.sv | 28 ++
 rtl/phase_error_detector_edge_synchroniser.sv | 25 ++
 rtl/phase_error_detector.sv | 169 ++++++++++++++++
 tb/tb_phase_error_detector.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adpll_pkg.sv
// Shared ADPLL types, default widths and helpers for the phase error detector
// and the error combiner that consumes its samples.
package adpll_pkg;

    localparam int PED_ERROR_WIDTH = 8;
    localparam int PED_COUNT_WIDTH = 10;
    localparam int PED_SLIP_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REF_LEAD = 2'd1,
        FB_LEAD  = 2'd2
    } ped_state_t;

    // Clamp an unsigned edge-to-edge count into a signed error of 'width' bits,
    // negated when the feedback edge led.
    function automatic int sat_count(input int unsigned count,
                                     input logic        negative,
                                     input int unsigned width);
        int unsigned mag_limit;
        mag_limit = 32'd1 << (width - 32'd1);
        if (negative) begin
            return (count >= mag_limit) ? -int'(mag_limit) : -int'(count);
        end
        return (count >= mag_limit - 32'd1) ? int'(mag_limit - 32'd1) : int'(count);
    endfunction

endpackage

// File: rtl/phase_error_detector_edge_synchroniser.sv
// Two-flop synchroniser followed by an edge-detect flop; emits a one-cycle
// pulse on each rising edge of an input asynchronous to clk_i.
module edge_synchroniser (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic async_i,
    output logic rise_o
);

    // stage_q[0] is the metastability catcher, [1] the settled sample, [2] its delay.
    logic [2:0] stage_q;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbour, forming a true shift chain.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[1:0], async_i};
        end
    end

    assign rise_o = stage_q[1] & ~stage_q[2];

endmodule

// File: rtl/phase_error_detector.sv
// Counts fast-clock cycles between reference and feedback rising edges and
// emits one saturated signed error per period. Optional PED_SLIP_COUNT_EN adds slip_count_o.
module phase_error_detector
    import adpll_pkg::*;
#(
    parameter int ERROR_WIDTH = PED_ERROR_WIDTH,
    parameter int COUNT_WIDTH = PED_COUNT_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          enable_i,
    input  logic                          ref_i,
    input  logic                          fb_i,
    output logic signed [ERROR_WIDTH-1:0] error_o,
    output logic                          error_valid_o
`ifdef PED_SLIP_COUNT_EN
    ,
    output logic [PED_SLIP_WIDTH-1:0]     slip_count_o
`endif
);

    localparam logic [COUNT_WIDTH-1:0]        CNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0]        CNT_ONE = COUNT_WIDTH'(1);
    localparam logic signed [ERROR_WIDTH-1:0] ERR_MAX = {1'b0, {(ERROR_WIDTH-1){1'b1}}};
    localparam logic signed [ERROR_WIDTH-1:0] ERR_MIN = {1'b1, {(ERROR_WIDTH-1){1'b0}}};

    logic ref_rise;
    logic fb_rise;

    ped_state_t                    state_q, state_d;
    logic [COUNT_WIDTH-1:0]        count_q, count_d;
    logic signed [ERROR_WIDTH-1:0] error_q, error_d;
    logic                          valid_q, valid_d;

    // Identical synchroniser depth on both paths keeps the measured error unbiased.
    edge_synchroniser u_ref_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .async_i   (ref_i),
        .rise_o    (ref_rise)
    );

    edge_synchroniser u_fb_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .async_i   (fb_i),
        .rise_o    (fb_rise)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case/if tree can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        error_d = error_q;
        valid_d = 1'b0;

        if (!enable_i) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ref_rise && fb_rise) begin
                        error_d = '0;
                        valid_d = 1'b1;
                    end else if (ref_rise) begin
                        state_d = REF_LEAD;
                        count_d = CNT_ONE;
                    end else if (fb_rise) begin
                        state_d = FB_LEAD;
                        count_d = CNT_ONE;
                    end
                end

                REF_LEAD: begin
                    if (fb_rise) begin
                        error_d = ERROR_WIDTH'(sat_count(32'(count_q), 1'b0, ERROR_WIDTH));
                        valid_d = 1'b1;
                        state_d = IDLE;
                        count_d = '0;
                    end else if (ref_rise) begin
                        // Second reference edge before any feedback: cycle slip.
                        error_d = ERR_MAX;
                        valid_d = 1'b1;
                        count_d = CNT_ONE;
                    end else if (count_q == CNT_MAX) begin
                        error_d = ERR_MAX;
                        valid_d = 1'b1;
                        state_d = IDLE;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end

                FB_LEAD: begin
                    if (ref_rise) begin
                        error_d = ERROR_WIDTH'(sat_count(32'(count_q), 1'b1, ERROR_WIDTH));
                        valid_d = 1'b1;
                        state_d = IDLE;
                        count_d = '0;
                    end else if (fb_rise) begin
                        error_d = ERR_MIN;
                        valid_d = 1'b1;
                        count_d = CNT_ONE;
                    end else if (count_q == CNT_MAX) begin
                        error_d = ERR_MIN;
                        valid_d = 1'b1;
                        state_d = IDLE;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end

                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            count_q <= '0;
            error_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            error_q <= error_d;
            valid_q <= valid_d;
        end
    end

    assign error_o       = error_q;
    assign error_valid_o = valid_q;

`ifdef PED_SLIP_COUNT_EN
    logic                      slip_event;
    logic [PED_SLIP_WIDTH-1:0] slip_q, slip_d;

    // Slips and timeouts are exactly the strobes not caused by a closing edge.
    assign slip_event = enable_i &&
        ((state_q == REF_LEAD && !fb_rise  && (ref_rise || count_q == CNT_MAX)) ||
         (state_q == FB_LEAD  && !ref_rise && (fb_rise  || count_q == CNT_MAX)));

    always_comb begin
        slip_d = slip_q;
        if (slip_event && slip_q != '1) begin
            slip_d = slip_q + PED_SLIP_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            slip_q <= '0;
        end else begin
            slip_q <= slip_d;
        end
    end

    assign slip_count_o = slip_q;
`endif

endmodule

// File: tb/tb_phase_error_detector.sv
// Directed bench for phase_error_detector: a timestamp-based model checked every
// cycle, plus literal expectations per scenario. Honours PED_SLIP_COUNT_EN.
module tb_phase_error_detector;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b1;
    logic              ref_in = 1'b0;
    logic              fb_in = 1'b0;
    logic signed [7:0] err;
    logic              err_valid;
`ifdef PED_SLIP_COUNT_EN
    logic [7:0]        slip_count;
`endif

    int checks   = 0;
    int failures = 0;

    phase_error_detector #(.ERROR_WIDTH(8), .COUNT_WIDTH(10)) dut (
        .clk_i         (clk),
        .reset_n_i     (rst_n),
        .enable_i      (enable),
        .ref_i         (ref_in),
        .fb_i          (fb_in),
        .error_o       (err),
        .error_valid_o (err_valid)
`ifdef PED_SLIP_COUNT_EN
        ,
        .slip_count_o  (slip_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: an open measurement is a (direction, start time) pair; the error is
    // the elapsed cycle count when the opposite edge arrives, clamped to 8 bits.
    typedef struct packed {
        int   mode;   // 0 none, 1 reference led, 2 feedback led
        int   start;
        int   t;
        int   err;
        logic valid;
        int   slips;
    } model_t;

    function automatic model_t model_step(model_t m, logic r, logic f, logic en);
        model_t n;
        int     d;
        n       = m;
        n.t     = m.t + 1;
        n.valid = 1'b0;
        d       = m.t - m.start;
        if (!en) begin
            n.mode = 0;
        end else if (m.mode == 0) begin
            if (r && f) begin
                n.err = 0; n.valid = 1'b1;
            end else if (r) begin
                n.mode = 1; n.start = m.t;
            end else if (f) begin
                n.mode = 2; n.start = m.t;
            end
        end else if (m.mode == 1) begin
            if (f) begin
                n.err = (d > 127) ? 127 : d; n.valid = 1'b1; n.mode = 0;
            end else if (r || d == 1023) begin
                n.err = 127; n.valid = 1'b1; n.start = m.t;
                n.mode = r ? 1 : 0;
                n.slips = (m.slips < 255) ? m.slips + 1 : 255;
            end
        end else begin
            if (r) begin
                n.err = (d > 128) ? -128 : -d; n.valid = 1'b1; n.mode = 0;
            end else if (f || d == 1023) begin
                n.err = -128; n.valid = 1'b1; n.start = m.t;
                n.mode = f ? 2 : 0;
                n.slips = (m.slips < 255) ? m.slips + 1 : 255;
            end
        end
        return n;
    endfunction

    // Raw input edges are seen by the detector two cycles after the input is sampled.
    model_t     m = '0;
    logic       ref_prev = 1'b0;
    logic       fb_prev = 1'b0;
    logic [1:0] ref_dly = '0;
    logic [1:0] fb_dly = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m        <= '0;
            ref_prev <= 1'b0;
            fb_prev  <= 1'b0;
            ref_dly  <= '0;
            fb_dly   <= '0;
        end else begin
            m        <= model_step(m, ref_dly[1], fb_dly[1], enable);
            ref_prev <= ref_in;
            fb_prev  <= fb_in;
            ref_dly  <= {ref_dly[0], ref_in & ~ref_prev};
            fb_dly   <= {fb_dly[0], fb_in & ~fb_prev};
        end
    end

    always @(negedge clk) begin
        check("error_o", int'(err), m.err);
        check("error_valid_o", int'(err_valid), int'(m.valid));
`ifdef PED_SLIP_COUNT_EN
        check("slip_count_o", int'(slip_count), m.slips);
`endif
    end

    int n_strobes = 0;
    int last_err  = 0;

    always @(negedge clk) begin
        if (err_valid) begin
            n_strobes <= n_strobes + 1;
            last_err  <= int'(err);
        end
    end

    int base;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_scn();
        ref_in = 1'b0;
        fb_in  = 1'b0;
        idle(8);
        base = n_strobes;
    endtask

    // first_ref selects which input rises first; the other follows 'gap' cycles later.
    task automatic run_pair(input logic first_ref, input int gap);
        start_scn();
        if (gap == 0) begin
            ref_in = 1'b1; fb_in = 1'b1;
        end else begin
            if (first_ref) ref_in = 1'b1; else fb_in = 1'b1;
            idle(gap);
            if (first_ref) fb_in = 1'b1; else ref_in = 1'b1;
        end
        idle(4);
        ref_in = 1'b0; fb_in = 1'b0;
        idle(8);
    endtask

    task automatic scn_result(input string name, input int strobes, input int value);
        check({name, "_strobes"}, n_strobes - base, strobes);
        check({name, "_error"}, last_err, value);
    endtask

    initial begin
        idle(3);
        check("reset_error", int'(err), 0);
        check("reset_valid", int'(err_valid), 0);
        @(negedge clk); #2 rst_n = 1'b1;

        run_pair(1'b1, 5);
        scn_result("ref_fb_5", 1, 5);

        run_pair(1'b0, 200);
        scn_result("fb_ref_200_sat", 1, -128);

        run_pair(1'b1, 0);
        scn_result("same_cycle", 1, 0);

        // Reference slip, then feedback closes the new measurement.
        start_scn();
        ref_in = 1'b1; idle(3); ref_in = 1'b0; idle(47);
        ref_in = 1'b1; idle(3); fb_in = 1'b1; idle(4);
        ref_in = 1'b0; fb_in = 1'b0; idle(8);
        scn_result("ref_slip", 2, 3);
`ifdef PED_SLIP_COUNT_EN
        check("slip_after_ref_slip", int'(slip_count), 1);
`endif

        // Timeout after 1023 cycles, then a feedback-led pair proves FSM is idle.
        start_scn();
        ref_in = 1'b1; idle(4); ref_in = 1'b0; idle(1030);
        scn_result("timeout", 1, 127);
        run_pair(1'b0, 4);
        scn_result("after_timeout", 1, -4);
`ifdef PED_SLIP_COUNT_EN
        check("slip_after_timeout", int'(slip_count), 2);
`endif

        run_pair(1'b1, 1);
        scn_result("ref_fb_1", 1, 1);

        run_pair(1'b1, 128);
        scn_result("ref_fb_128_sat", 1, 127);

        // Feedback slip, then reference closes at -2.
        start_scn();
        fb_in = 1'b1; idle(3); fb_in = 1'b0; idle(27);
        fb_in = 1'b1; idle(2); ref_in = 1'b1; idle(4);
        ref_in = 1'b0; fb_in = 1'b0; idle(8);
        scn_result("fb_slip", 2, -2);

        // Asynchronous reset ten cycles into a reference-led measurement.
        start_scn();
        ref_in = 1'b1; idle(10);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_error", int'(err), 0);
        check("midreset_valid", int'(err_valid), 0);
`ifdef PED_SLIP_COUNT_EN
        check("midreset_slip", int'(slip_count), 0);
`endif
        ref_in = 1'b0;
        idle(3);
        #2 rst_n = 1'b1;
        idle(6);
        check("post_reset_strobes", n_strobes - base, 0);
        run_pair(1'b1, 7);
        scn_result("after_reset", 1, 7);

        // Disable mid-measurement: no strobe, error holds, fresh start after enable.
        start_scn();
        ref_in = 1'b1; idle(5);
        enable = 1'b0; ref_in = 1'b0; idle(2);
        fb_in = 1'b1; idle(6);
        scn_result("disabled_hold", 0, 7);
        check("disabled_error_o", int'(err), 7);
        fb_in = 1'b0; idle(3);
        enable = 1'b1; idle(2);
        ref_in = 1'b1; idle(9); fb_in = 1'b1; idle(4);
        ref_in = 1'b0; fb_in = 1'b0; idle(8);
        scn_result("after_enable", 1, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
